// File: rtl/dircc_processing_mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester processing memory arbiter.
package dircc_processing_mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W    = 14;
    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_NUM_WORDS = 15000;

    typedef enum logic {
        RID_M0 = 1'b0,
        RID_M1 = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    oor;
    } pend_rd_t;

    localparam pend_rd_t PEND_IDLE = '{valid: 1'b0, id: RID_M0, oor: 1'b0};

    function automatic logic addr_oor(input logic [31:0] addr, input int unsigned num_words);
        return addr >= num_words;
    endfunction

endpackage

// File: rtl/dircc_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves past each winner.
module dircc_rr_arbiter2
    import dircc_processing_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output req_id_t    grant_id
);

    req_id_t ptr;

    // A lone requester wins regardless of the pointer; the pointer only breaks ties.
    always_comb begin
        grant_id = RID_M0;
        if (req == 2'b11) begin
            grant_id = ptr;
        end else if (req[1]) begin
            grant_id = RID_M1;
        end
        grant = '0;
        if (!reset && (req != 2'b00)) begin
            grant = (grant_id == RID_M1) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= RID_M0;
        end else if (grant != 2'b00) begin
            ptr <= (grant_id == RID_M1) ? RID_M0 : RID_M1;
        end
    end

endmodule

// File: rtl/dircc_processing_mem_arbiter.sv
// Shares one single-cycle-latency memory port between two requesters, with
// out-of-range filtering and a sticky error flag.
module dircc_processing_mem_arbiter
    import dircc_processing_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,

    output logic                  err_oor,
    input  logic                  err_clear
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic [1:0]        req;
    logic [1:0]        grant;
    req_id_t           grant_id;

    logic              granted;
    logic              fwd;
    logic              sel_write;
    logic              sel_oor;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;

    pend_rd_t          pend_q;
    logic              err_q;
    logic              rd_live;
    logic [DATA_W-1:0] rd_data;

    // Read+write together counts as a write, so either strobe is a request.
    assign req = {m1_read | m1_write, m0_read | m0_write};

    dircc_rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        granted = |grant;
        if (grant_id == RID_M1) begin
            sel_addr  = m1_address;
            sel_be    = m1_byteenable;
            sel_wdata = m1_writedata;
            sel_write = m1_write;
        end else begin
            sel_addr  = m0_address;
            sel_be    = m0_byteenable;
            sel_wdata = m0_writedata;
            sel_write = m0_write;
        end
        sel_oor = addr_oor(32'(sel_addr), NUM_WORDS);
        fwd     = granted & ~sel_oor;
    end

    assign m0_waitrequest = reset | (req[0] & ~grant[0]);
    assign m1_waitrequest = reset | (req[1] & ~grant[1]);

    // Out-of-range requests are accepted but never reach the memory.
    assign mem_chipselect = fwd;
    assign mem_write      = fwd & sel_write;
    assign mem_address    = fwd ? sel_addr  : '0;
    assign mem_byteenable = fwd ? sel_be    : '0;
    assign mem_writedata  = fwd ? sel_wdata : '0;
    assign mem_clken      = ~reset & (granted | pend_q.valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= PEND_IDLE;
            err_q  <= 1'b0;
        end else begin
            pend_q <= '{valid: granted & ~sel_write, id: grant_id, oor: sel_oor};
            err_q  <= (granted & sel_oor) | (err_q & ~err_clear);
        end
    end

    // Gating with reset drops a read that was in flight when reset arrived.
    assign rd_live          = ~reset & pend_q.valid;
    assign rd_data          = pend_q.oor ? '0 : mem_readdata;
    assign m0_readdatavalid = rd_live & (pend_q.id == RID_M0);
    assign m1_readdatavalid = rd_live & (pend_q.id == RID_M1);
    assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
    assign m1_readdata      = m1_readdatavalid ? rd_data : '0;

    assign err_oor = err_q & ~reset;

endmodule

// File: tb/tb_dircc_processing_mem_arbiter.sv
// Randomized + directed scoreboard bench for dircc_processing_mem_arbiter.
module tb_dircc_processing_mem_arbiter;

    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned NUM_WORDS = 15000;
    localparam int unsigned BE_W      = DATA_W / 8;
    localparam int unsigned MEM_SIZE  = 1 << ADDR_W;

    typedef struct {
        bit          rd;
        bit          wr;
        int unsigned addr;
        bit [1:0]    be;
        bit [15:0]   data;
        int unsigned gap;
    } stim_t;

    typedef struct {
        int          id;
        bit [15:0]   data;
        int unsigned due;
    } exp_rd_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
    logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
    logic [BE_W-1:0]   m0_byteenable = '0, m1_byteenable = '0;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic              err_oor;
    logic              err_clear = 1'b0;

    stim_t       stimq0[$];
    stim_t       stimq1[$];
    exp_rd_t     sbq[$];
    bit          active[2];
    logic [15:0] ref_mem[MEM_SIZE];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    dircc_processing_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .err_oor          (err_oor),
        .err_clear        (err_clear)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] init_word(input int unsigned i);
        return 16'(i * 40503 + 12345);
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = wd[7:0];
        if (be[1]) r[15:8] = wd[15:8];
        return r;
    endfunction

    function automatic stim_t mk(input bit rd, input bit wr, input int unsigned addr,
                                 input bit [1:0] be, input bit [15:0] data, input int unsigned gap);
        stim_t s;
        s.rd = rd; s.wr = wr; s.addr = addr; s.be = be; s.data = data; s.gap = gap;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        int unsigned k, op, addr;
        k = $urandom_range(0, 19);
        if (k == 0)      addr = NUM_WORDS - 1;
        else if (k == 1) addr = NUM_WORDS;
        else if (k == 2) addr = MEM_SIZE - 1;
        else             addr = $urandom_range(0, 63);
        op = $urandom_range(0, 9);
        return mk(op <= 4, op == 0 || op >= 5, addr, 2'($urandom_range(0, 3)),
                  16'($urandom), $urandom_range(0, 2));
    endfunction

    // Memory device: synchronous RAM with one cycle read latency.
    initial begin : memory_device
        logic [15:0] dev_mem[MEM_SIZE];
        for (int i = 0; i < MEM_SIZE; i++) dev_mem[i] = init_word(i);
        mem_readdata = '0;
        forever begin
            @(posedge clk);
            if (mem_chipselect && mem_clken) begin
                if (mem_write) dev_mem[mem_address] = merge(dev_mem[mem_address], mem_writedata, mem_byteenable);
                else           mem_readdata <= dev_mem[mem_address];
            end
        end
    end

    task automatic drive(input int r, input bit act, input stim_t s);
        if (r == 0) begin
            m0_read       = act && s.rd;
            m0_write      = act && s.wr;
            m0_address    = act ? ADDR_W'(s.addr) : '0;
            m0_byteenable = act ? s.be : '0;
            m0_writedata  = act ? s.data : '0;
        end else begin
            m1_read       = act && s.rd;
            m1_write      = act && s.wr;
            m1_address    = act ? ADDR_W'(s.addr) : '0;
            m1_byteenable = act ? s.be : '0;
            m1_writedata  = act ? s.data : '0;
        end
    endtask

    // Each requester holds its request until it sees waitrequest low.
    task automatic run_requester(input int r);
        stim_t       s;
        int unsigned idle;
        bit          acc;
        s = mk(0, 0, 0, 0, 0, 0);
        idle = 0;
        forever begin
            @(negedge clk);
            acc = (r == 0) ? ((m0_read || m0_write) && !m0_waitrequest)
                           : ((m1_read || m1_write) && !m1_waitrequest);
            if (active[r] && acc && !reset) active[r] = 1'b0;
            @(posedge clk);
            #1;
            if (!active[r]) begin
                if (idle > 0) begin
                    idle--;
                end else if (r == 0 && stimq0.size() > 0) begin
                    s = stimq0.pop_front(); active[r] = 1'b1; idle = s.gap;
                end else if (r == 1 && stimq1.size() > 0) begin
                    s = stimq1.pop_front(); active[r] = 1'b1; idle = s.gap;
                end
            end
            drive(r, active[r], s);
        end
    endtask

    initial run_requester(0);
    initial run_requester(1);

    // Reference model: decides grants from the round-robin rule and predicts responses.
    initial begin : model
        int          pref, g;
        bit          prev_rd, exp_err, nxt_err, r0, r1, wr, oor;
        int unsigned addr;
        logic [1:0]  be;
        logic [15:0] wd;
        exp_rd_t     e;
        pref = 0; prev_rd = 0; exp_err = 0;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_waitrequest", 32'({m1_waitrequest, m0_waitrequest}), 32'(2'b11));
                check("rst_mem_ctrl", 32'({mem_chipselect, mem_write, mem_clken}), 32'(0));
                check("rst_mem_bus", {mem_address, mem_byteenable, mem_writedata}, 32'(0));
                check("rst_err_oor", 32'(err_oor), 32'(0));
                pref = 0; prev_rd = 0; exp_err = 0;
            end else begin
                r0 = m0_read || m0_write;
                r1 = m1_read || m1_write;
                g = -1;
                if (r0 && r1)  g = pref;
                else if (r0)   g = 0;
                else if (r1)   g = 1;
                check("waitrequest", 32'({r1 && m1_waitrequest, r0 && m0_waitrequest}),
                      32'({r1 && g != 1, r0 && g != 0}));
                nxt_err = exp_err && !err_clear;
                if (g >= 0) begin
                    wr   = (g == 0) ? m0_write : m1_write;
                    addr = (g == 0) ? 32'(m0_address) : 32'(m1_address);
                    be   = (g == 0) ? m0_byteenable : m1_byteenable;
                    wd   = (g == 0) ? m0_writedata : m1_writedata;
                    oor  = addr >= NUM_WORDS;
                    check("mem_ctrl", 32'({mem_chipselect, mem_write, mem_clken}),
                          32'({!oor, !oor && wr, 1'b1}));
                    check("mem_bus", {mem_address, mem_byteenable, mem_writedata},
                          oor ? 32'(0) : {ADDR_W'(addr), be, wd});
                    if (!oor && wr) ref_mem[addr] = merge(ref_mem[addr], wd, be);
                    if (!wr) begin
                        e.id = g;
                        e.data = oor ? 16'h0000 : ref_mem[addr];
                        e.due = cyc + 1;
                        sbq.push_back(e);
                    end
                    if (oor) nxt_err = 1'b1;
                    pref = 1 - g;
                    prev_rd = !wr;
                end else begin
                    check("mem_ctrl_idle", 32'({mem_chipselect, mem_write, mem_clken}),
                          32'({1'b0, 1'b0, prev_rd}));
                    check("mem_bus_idle", {mem_address, mem_byteenable, mem_writedata}, 32'(0));
                    prev_rd = 1'b0;
                end
                check("err_oor", 32'(err_oor), 32'(exp_err));
                exp_err = nxt_err;
            end
        end
    end

    // Monitor: pops an expected read whenever the DUT presents readdatavalid.
    initial begin : monitor
        exp_rd_t    e;
        logic [1:0] rdv;
        forever begin
            @(negedge clk);
            rdv = {m1_readdatavalid, m0_readdatavalid};
            if (reset) begin
                check("rst_readdatavalid", 32'(rdv), 32'(0));
                check("rst_readdata", {m1_readdata, m0_readdata}, 32'(0));
                sbq.delete();
            end else begin
                if (!m0_readdatavalid) check("m0_readdata_idle", 32'(m0_readdata), 32'(0));
                if (!m1_readdatavalid) check("m1_readdata_idle", 32'(m1_readdata), 32'(0));
                if (rdv != 2'b00) begin
                    if (sbq.size() == 0) begin
                        check("rd_unexpected", 32'(rdv), 32'(0));
                    end else begin
                        e = sbq.pop_front();
                        check("rd_valid_id", 32'(rdv), (e.id == 1) ? 32'(2'b10) : 32'(2'b01));
                        check("rd_data", (e.id == 1) ? 32'(m1_readdata) : 32'(m0_readdata), 32'(e.data));
                        check("rd_latency", cyc, e.due);
                    end
                end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    e = sbq.pop_front();
                    check("rd_missing", 32'(rdv), (e.id == 1) ? 32'(2'b10) : 32'(2'b01));
                end
            end
        end
    end

    task automatic wait_idle(input int unsigned limit, input bit rand_clear);
        int unsigned n, pending;
        n = 0;
        pending = stimq0.size() + stimq1.size() + active[0] + active[1];
        while (pending != 0 && n < limit) begin
            @(posedge clk);
            #1;
            err_clear = rand_clear && ($urandom_range(0, 7) == 0);
            n++;
            pending = stimq0.size() + stimq1.size() + active[0] + active[1];
        end
        check("idle_timeout", pending, 32'(0));
        repeat (3) @(posedge clk);
        #1;
        err_clear = 1'b0;
    endtask

    initial begin : main
        int unsigned n;
        bit          acc;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Write then read back on m0.
        @(negedge clk);
        stimq0.push_back(mk(0, 1, 32'h10, 2'b11, 16'hBEEF, 0));
        stimq0.push_back(mk(1, 0, 32'h10, 2'b11, 16'h0000, 0));
        wait_idle(100, 1'b0);

        // Both requesters reading continuously.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            stimq0.push_back(mk(1, 0, 32'h10 + i, 2'b11, 16'h0, 0));
            stimq1.push_back(mk(1, 0, 32'h20 + i, 2'b11, 16'h0, 0));
        end
        wait_idle(100, 1'b0);

        // Out-of-range read, then clear the flag.
        @(negedge clk);
        stimq1.push_back(mk(1, 0, NUM_WORDS, 2'b11, 16'h0, 0));
        wait_idle(100, 1'b0);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Partial write at the last valid word.
        @(negedge clk);
        stimq0.push_back(mk(0, 1, NUM_WORDS - 1, 2'b11, 16'hFFFF, 0));
        stimq0.push_back(mk(0, 1, NUM_WORDS - 1, 2'b01, 16'h12AB, 0));
        stimq0.push_back(mk(1, 0, NUM_WORDS - 1, 2'b11, 16'h0, 0));
        wait_idle(100, 1'b0);

        // Reset arriving while a read is in flight.
        @(negedge clk);
        stimq0.push_back(mk(1, 0, 32'h5, 2'b11, 16'h0, 0));
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = m0_read && !m0_waitrequest;
            n++;
        end
        check("reset_read_accept", 32'(acc), 32'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        stimq0.push_back(mk(0, 1, 32'h30, 2'b11, 16'hA5A5, 0));
        stimq1.push_back(mk(0, 1, 32'h31, 2'b11, 16'h5A5A, 0));
        wait_idle(100, 1'b0);

        // Randomized traffic with random flag clears.
        @(negedge clk);
        for (int i = 0; i < 250; i++) begin
            stimq0.push_back(rand_stim());
            stimq1.push_back(rand_stim());
        end
        wait_idle(5000, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drain", sbq.size(), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
